cafe_change_dispenser: RTL and testbench
========================================

// Module: cafe_change_dispenser
// PURPOSE
//  Coin-return side of the cafe vending machine. Accepts a change request (in 100-colon units)
//  from the vending FSM and drives the 500/100 coin hopper ejectors, greedy largest-coin-first.
//  Tracks hopper inventory, confirms each coin with the drop sensor, and reports shortfall or jam.
// PARAMETERS
//  AMT_W        5   width of change amount, in 100-colon units (max 31 = 3100 colones)
//  INV_W        8   width of each hopper inventory counter (saturates at 2**INV_W-1)
//  PULSE_CYC    4   cycles an eject line stays high per coin (>=1)
//  TIMEOUT_CYC  16  cycles allowed after pulse end for coin_sensed before jam (>=1)
//  GAP_CYC      2   idle cycles between consecutive coins (>=0)
// PORTS
//  clk          in   1      clock
//  reset        in   1      asynchronous, active-high reset
//  req_valid    in   1      change request valid
//  req_ready    out  1      high only in IDLE; request accepted on valid&&ready edge
//  req_amount   in   AMT_W  change owed, 100-colon units; sampled at accept
//  inc_500      in   1      one 500 coin added to hopper (pulse per coin)
//  inc_100      in   1      one 100 coin added to hopper (pulse per coin)
//  coin_sensed  in   1      hopper drop sensor, one-cycle pulse per coin leaving
//  eject_500    out  1      500 ejector drive
//  eject_100    out  1      100 ejector drive
//  done         out  1      one-cycle pulse: request finished
//  short        out  1      status: finished with remaining>0 (insufficient coins); held until next accept
//  jam          out  1      status: sensor timeout; held until next accept
//  remaining    out  AMT_W  change still owed; held after done
//  inv_500      out  INV_W  500 coins in hopper
//  inv_100      out  INV_W  100 coins in hopper
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; all other outputs 0 incl. inv_*; takes effect immediately (ejectors drop).
//  States: IDLE, SELECT, PULSE, WAIT_SENSE, GAP, DONE.
//  IDLE: req_ready=1. On accept: remaining<=req_amount, short<=0, jam<=0, go SELECT.
//  SELECT (1 cycle): remaining>=5 && inv_500>0 -> coin=500, PULSE;
//    else remaining>=1 && inv_100>0 -> coin=100, PULSE; else DONE (short<=remaining!=0).
//  PULSE: selected eject_* high exactly PULSE_CYC cycles, never both; then WAIT_SENSE.
//  Sensing window opens first PULSE cycle. coin_sensed in PULSE or WAIT_SENSE: remaining -= 5 or 1,
//    inv of that coin -= 1; coin is credited once per pulse (extra sensed pulses ignored).
//    Sensed during PULSE: pulse still completes full length, then GAP (WAIT_SENSE skipped).
//  WAIT_SENSE: sensed -> GAP; TIMEOUT_CYC cycles with no sense -> jam<=1, DONE (remaining unchanged).
//  GAP: GAP_CYC cycles (0 = pass through), then SELECT.
//  DONE (1 cycle): done=1, short = (remaining!=0 && !jam); then IDLE.
//  Refill: inc_* increments inventory in any state, saturating; simultaneous inc and credit on
//    same coin type -> count unchanged. coin_sensed outside a window is ignored.
//  req_amount=0: accept edge -> SELECT -> DONE; done high 2nd cycle after accept, short=0.
//  req_valid in non-IDLE states ignored (ready=0); requester holds until accepted.
//  Widths: remaining never underflows (500 chosen only if remaining>=5).
// TESTING
//  Reset, inc_500 x3, inc_100 x5; req 7 -> one eject_500 (4 cyc), two eject_100 with sensor -> done, short=0, inv 2/3.
//  inv_500=0, inv_100=3; req 5 -> three 100 coins, done, short=1, remaining=2, inv_100=0.
//  req 0 -> no eject, done exactly 2 cycles after accept, short=0, jam=0.
//  req 1, never assert coin_sensed -> eject_100 4 cyc, done after 16 wait cycles, jam=1, remaining=1, inv unchanged.
//  inc_100 same cycle as credited 100-coin sense -> inv_100 unchanged; inv at 255 + inc -> stays 255.
//  Assert reset mid-PULSE -> eject_* low same cycle, req_ready=1, inv_*=0, no done pulse.

Source files
------------

// File: rtl/cafe_change_dispenser.sv
// cafe_change_dispenser
//   Coin-return side of the cafe vending machine. Pays out a change request
//   (in 100-colon units) greedily: 500 coins first, then 100 coins. Each coin
//   is one eject pulse, confirmed by the drop sensor. The block also tracks the
//   inventory of both hoppers and reports a shortfall or a jam.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   IDLE       | waiting for a request, req_ready high
//   SELECT     | pick next coin (500, 100) or finish
//   PULSE      | drive the selected ejector for PULSE_CYC cycles
//   WAIT_SENSE | pulse over, no coin sensed yet; jam after TIMEOUT_CYC cycles
//   GAP        | GAP_CYC idle cycles between coins
//   DONE       | one-cycle done pulse
//
// Ports
//   clk, reset              clock, async active-high reset
//   req_valid/req_ready     request handshake, req_amount sampled at accept
//   inc_500, inc_100        refill pulses, one per coin added
//   coin_sensed             drop sensor pulse, one per coin leaving
//   eject_500, eject_100    ejector drives
//   done                    one-cycle pulse when a request finishes
//   short, jam              completion status, held until next accept
//   remaining               change still owed
//   inv_500, inv_100        hopper inventories
module cafe_change_dispenser #(
  parameter int AMT_W       = 5,
  parameter int INV_W       = 8,
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int GAP_CYC     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             inc_500,
  input  logic             inc_100,
  input  logic             coin_sensed,
  output logic             eject_500,
  output logic             eject_100,
  output logic             done,
  output logic             short,
  output logic             jam,
  output logic [AMT_W-1:0] remaining,
  output logic [INV_W-1:0] inv_500,
  output logic [INV_W-1:0] inv_100
);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, WAIT_SENSE, GAP, DONE} state_t;

  localparam int MAX_A = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
  localparam int MAX_C = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [AMT_W-1:0] AMT_FIVE   = AMT_W'(5);
  localparam logic [AMT_W-1:0] AMT_ONE    = AMT_W'(1);
  localparam logic [INV_W-1:0] INV_MAX    = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_val;
  logic             cnt_ld;
  logic             coin_500_q;   // coin type of the current pulse
  logic             credited_q;   // current coin already credited
  logic             accept, credit, sel_any, sel_500, set_short, set_jam, sense_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_ld    = 1'b0;
    cnt_val   = '0;
    accept    = 1'b0;
    credit    = 1'b0;
    sel_any   = 1'b0;
    sel_500   = 1'b0;
    set_short = 1'b0;
    set_jam   = 1'b0;
    req_ready = (state_q == IDLE);
    eject_500 = (state_q == PULSE) && coin_500_q;
    eject_100 = (state_q == PULSE) && !coin_500_q;
    done      = (state_q == DONE);
    sense_ok  = coin_sensed && !credited_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (remaining >= AMT_FIVE && inv_500 != '0) begin
          sel_any = 1'b1;
          sel_500 = 1'b1;
          state_d = PULSE;
          cnt_ld  = 1'b1;
          cnt_val = PULSE_LD;
        end else if (remaining != '0 && inv_100 != '0) begin
          sel_any = 1'b1;
          state_d = PULSE;
          cnt_ld  = 1'b1;
          cnt_val = PULSE_LD;
        end else begin
          set_short = 1'b1;
          state_d   = DONE;
        end
      end
      PULSE: begin
        credit = sense_ok;
        if (cnt_q == '0) begin
          // a coin sensed during the pulse skips the sensor wait
          if (credited_q || sense_ok) begin
            if (GAP_CYC == 0) state_d = SELECT;
            else begin
              state_d = GAP;
              cnt_ld  = 1'b1;
              cnt_val = GAP_LD;
            end
          end else begin
            state_d = WAIT_SENSE;
            cnt_ld  = 1'b1;
            cnt_val = TIMEOUT_LD;
          end
        end
      end
      WAIT_SENSE: begin
        if (coin_sensed) begin
          credit = 1'b1;
          if (GAP_CYC == 0) state_d = SELECT;
          else begin
            state_d = GAP;
            cnt_ld  = 1'b1;
            cnt_val = GAP_LD;
          end
        end else if (cnt_q == '0) begin
          set_jam = 1'b1;
          state_d = DONE;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = SELECT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] cur,
                                                input logic inc, input logic dec);
    inv_next = cur;
    if (inc && !dec && cur != INV_MAX)   inv_next = cur + 1'b1;
    else if (dec && !inc && cur != '0)   inv_next = cur - 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      coin_500_q <= 1'b0;
      credited_q <= 1'b0;
      remaining  <= '0;
      short      <= 1'b0;
      jam        <= 1'b0;
      inv_500    <= '0;
      inv_100    <= '0;
    end else begin
      if (cnt_ld)             cnt_q <= cnt_val;
      else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
      if (sel_any) begin
        coin_500_q <= sel_500;
        credited_q <= 1'b0;
      end else if (credit) begin
        credited_q <= 1'b1;
      end
      if (accept) begin
        remaining <= req_amount;
        short     <= 1'b0;
        jam       <= 1'b0;
      end else begin
        if (credit)    remaining <= remaining - (coin_500_q ? AMT_FIVE : AMT_ONE);
        if (set_short) short     <= (remaining != '0);
        if (set_jam)   jam       <= 1'b1;
      end
      inv_500 <= inv_next(inv_500, inc_500, credit && coin_500_q);
      inv_100 <= inv_next(inv_100, inc_100, credit && !coin_500_q);
    end
  end

endmodule

// File: tb/tb_cafe_change_dispenser.sv
// Testbench for cafe_change_dispenser: directed scenarios plus randomized
// requests checked against a greedy payout model of the hoppers.
module tb_cafe_change_dispenser;

  localparam int AMT_W = 5;
  localparam int INV_W = 8;
  localparam int PW    = AMT_W + 2 + 2 * INV_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount = '0;
  logic             inc_500 = 1'b0;
  logic             inc_100 = 1'b0;
  logic             coin_sensed = 1'b0;
  logic             eject_500, eject_100, done, short, jam;
  logic [AMT_W-1:0] remaining;
  logic [INV_W-1:0] inv_500, inv_100;

  int n_tests = 0;
  int n_fail  = 0;
  int m5 = 0;   // model inventories
  int m1 = 0;

  cafe_change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W), .PULSE_CYC(4),
                          .TIMEOUT_CYC(16), .GAP_CYC(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_amount(req_amount), .inc_500(inc_500), .inc_100(inc_100),
    .coin_sensed(coin_sensed), .eject_500(eject_500), .eject_100(eject_100),
    .done(done), .short(short), .jam(jam), .remaining(remaining),
    .inv_500(inv_500), .inv_100(inv_100));

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pack(input int r, input bit s, input bit j,
                                         input int a, input int b);
    return {AMT_W'(r), s, j, INV_W'(a), INV_W'(b)};
  endfunction

  function automatic logic [PW-1:0] got();
    return {remaining, short, jam, inv_500, inv_100};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0; inc_500 = 1'b0; inc_100 = 1'b0; coin_sensed = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m5 = 0; m1 = 0;
  endtask

  task automatic refill(input int a5, input int a1);
    int n;
    n = (a5 > a1) ? a5 : a1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inc_500 = (i < a5);
      inc_100 = (i < a1);
    end
    @(negedge clk);
    inc_500 = 1'b0; inc_100 = 1'b0;
    m5 = (m5 + a5 > 255) ? 255 : m5 + a5;
    m1 = (m1 + a1 > 255) ? 255 : m1 + a1;
  endtask

  // Issues one request and acts as the hopper: answers each eject pulse with a
  // sensor pulse at a random point of its window. Returns coins ejected, the
  // cycle (from accept) at which done was seen and a count of pulse anomalies.
  task automatic run_req(input int amt, input bit respond, input bit dup, input bit inc_on_sense,
                         output int n5, output int n1, output int cyc, output int bad);
    int since, dly, plen;
    bit prev, cur, dup_pend, inc_done;
    n5 = 0; n1 = 0; bad = 0; since = -1; dly = 0; plen = 0;
    prev = 0; dup_pend = 0; inc_done = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_amount = AMT_W'(amt);
    @(negedge clk);
    req_valid = 1'b0;
    for (cyc = 1; cyc <= 600; cyc++) begin
      coin_sensed = 1'b0;
      inc_100 = 1'b0;
      if (eject_500 && eject_100) bad++;
      cur = eject_500 | eject_100;
      if (cur && !prev) begin
        since = 0; plen = 0;
        dly = $urandom_range(0, 19);
        if (eject_500) n5++; else n1++;
      end else if (since >= 0) since++;
      if (cur) plen++;
      else if (prev && plen != 4) bad++;
      prev = cur;
      if (done) break;
      if (dup_pend) begin coin_sensed = 1'b1; dup_pend = 0; end
      if (respond && since == dly) begin
        coin_sensed = 1'b1;
        dup_pend = dup;
        if (inc_on_sense && !inc_done) begin inc_100 = 1'b1; inc_done = 1; end
      end
      @(negedge clk);
    end
    coin_sensed = 1'b0;
    inc_100 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({req_ready, eject_500, eject_100, done, got()} !== {4'b1000, pack(0, 0, 0, 0, 0)}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h",
               {req_ready, eject_500, eject_100, done, got()}, {4'b1000, pack(0, 0, 0, 0, 0)});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int n5, n1, cyc, bad;
    do_reset();
    refill(3, 5);
    run_req(7, 1, 0, 0, n5, n1, cyc, bad);
    n_tests++;
    if ({n5, n1, bad} !== {32'd1, 32'd2, 32'd0} || cyc > 600) begin
      n_fail++;
      $display("FAIL basic_coins: got n5=%0d n1=%0d bad=%0d cyc=%0d expected 1 2 0", n5, n1, bad, cyc);
    end
    n_tests++;
    if (got() !== pack(0, 0, 0, 2, 3)) begin
      n_fail++;
      $display("FAIL basic_status: got %h expected %h", got(), pack(0, 0, 0, 2, 3));
    end
    m5 = 2; m1 = 3;
  endtask

  task automatic test_short();
    int n5, n1, cyc, bad;
    do_reset();
    refill(0, 3);
    run_req(5, 1, 1, 0, n5, n1, cyc, bad);
    n_tests++;
    if ({n5, n1, bad} !== {32'd0, 32'd3, 32'd0} || cyc > 600) begin
      n_fail++;
      $display("FAIL short_coins: got n5=%0d n1=%0d bad=%0d cyc=%0d expected 0 3 0", n5, n1, bad, cyc);
    end
    n_tests++;
    if (got() !== pack(2, 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL short_status: got %h expected %h", got(), pack(2, 1, 0, 0, 0));
    end
    m5 = 0; m1 = 0;
  endtask

  task automatic test_zero();
    int n5, n1, cyc, bad;
    run_req(0, 1, 0, 0, n5, n1, cyc, bad);
    n_tests++;
    if (cyc !== 2 || n5 + n1 != 0) begin
      n_fail++;
      $display("FAIL zero_timing: got done at %0d coins %0d expected 2 0", cyc, n5 + n1);
    end
    n_tests++;
    if (got() !== pack(0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL zero_status: got %h expected %h", got(), pack(0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_jam();
    int n5, n1, cyc, bad;
    refill(0, 2);
    run_req(1, 0, 0, 0, n5, n1, cyc, bad);
    n_tests++;
    if (cyc !== 22 || {n5, n1, bad} !== {32'd0, 32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL jam_timing: got done at %0d n5=%0d n1=%0d bad=%0d expected 22 0 1 0",
               cyc, n5, n1, bad);
    end
    n_tests++;
    if (got() !== pack(1, 0, 1, 0, 2)) begin
      n_fail++;
      $display("FAIL jam_status: got %h expected %h", got(), pack(1, 0, 1, 0, 2));
    end
  endtask

  task automatic test_collision_saturate();
    int n5, n1, cyc, bad;
    run_req(1, 1, 0, 1, n5, n1, cyc, bad);
    n_tests++;
    if (got() !== pack(0, 0, 0, 0, 2) || n1 != 1 || cyc > 600) begin
      n_fail++;
      $display("FAIL inc_collision: got %h n1=%0d expected %h n1=1", got(), n1, pack(0, 0, 0, 0, 2));
    end
    refill(0, 253);
    n_tests++;
    if (inv_100 !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate_reach: got %0d expected 255", inv_100);
    end
    refill(0, 3);
    n_tests++;
    if (inv_100 !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate_hold: got %0d expected 255", inv_100);
    end
  endtask

  task automatic test_reset_mid_pulse();
    bit seen, bad_done;
    seen = 0; bad_done = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_amount = AMT_W'(3);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = eject_100;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midpulse_start: eject_100 never rose expected 1");
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({eject_500, eject_100, req_ready, inv_500, inv_100} !== {3'b001, 16'h0}) begin
      n_fail++;
      $display("FAIL midpulse_reset: got %h expected %h",
               {eject_500, eject_100, req_ready, inv_500, inv_100}, {3'b001, 16'h0});
    end
    @(negedge clk);
    reset = 1'b0;
    m5 = 0; m1 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || eject_100 || eject_500 || !req_ready) bad_done = 1;
    end
    n_tests++;
    if (bad_done) begin
      n_fail++;
      $display("FAIL midpulse_quiet: got activity after reset expected idle");
    end
  endtask

  task automatic test_random();
    int n5, n1, cyc, bad, amt, e5, e1, r;
    bit respond;
    logic [PW-1:0] exp_v;
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) == 0) refill($urandom_range(0, 3), $urandom_range(0, 6));
      amt = $urandom_range(0, 31);
      respond = ($urandom_range(0, 7) != 0);
      run_req(amt, respond, $urandom_range(0, 1), 0, n5, n1, cyc, bad);
      e5 = 0; e1 = 0;
      if (respond) begin
        e5 = (amt / 5 < m5) ? amt / 5 : m5;
        r  = amt - 5 * e5;
        e1 = (r < m1) ? r : m1;
        r  = r - e1;
        m5 = m5 - e5;
        m1 = m1 - e1;
        exp_v = pack(r, r != 0, 0, m5, m1);
      end else begin
        if (amt >= 5 && m5 > 0)      e5 = 1;
        else if (amt >= 1 && m1 > 0) e1 = 1;
        exp_v = pack(amt, (e5 + e1 == 0) && amt != 0, (e5 + e1) != 0, m5, m1);
      end
      n_tests++;
      if ({n5, n1, bad} !== {e5, e1, 32'd0} || cyc > 600) begin
        n_fail++;
        $display("FAIL rand_coins[%0d]: amt=%0d got n5=%0d n1=%0d bad=%0d cyc=%0d expected %0d %0d 0",
                 t, amt, n5, n1, bad, cyc, e5, e1);
      end
      n_tests++;
      if (got() !== exp_v) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: amt=%0d got %h expected %h", t, amt, got(), exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_zero();
    test_jam();
    test_collision_saturate();
    test_reset_mid_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
